// File: rtl/ctrl_wb_stage_if.sv
// MEM->WB control bundle: MEM-side request fields and WB-side registered fields.
interface ctrl_wb_stage_if #(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
);
  logic              valid_MEM;
  logic              reg_write_en_MEM;
  logic [ADDR_W-1:0] rd_MEM;
  logic [SEL_W-1:0]  wb_sel_MEM;
  logic              valid_WB;
  logic              reg_write_en_WB;
  logic [ADDR_W-1:0] rd_WB;
  logic [SEL_W-1:0]  wb_sel_WB;

  modport master (
    output valid_MEM, reg_write_en_MEM,
    output rd_MEM, wb_sel_MEM,
    input  valid_WB, reg_write_en_WB,
    input  rd_WB, wb_sel_WB
  );

  modport slave (
    input  valid_MEM, reg_write_en_MEM,
    input  rd_MEM, wb_sel_MEM,
    output valid_WB, reg_write_en_WB,
    output rd_WB, wb_sel_WB
  );
endinterface

// File: rtl/ctrl_wb_stage.sv
// MEM->WB control register with x0 suppression and WB forwarding match.
// Define CTRL_WB_PERF_EN to build retire/stall/squash counters.
module ctrl_wb_stage #(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  ctrl_wb_stage_if.slave    bus,
  input  logic              bubbleW,
  input  logic              flushW,
  input  logic [ADDR_W-1:0] rs1_EX,
  input  logic [ADDR_W-1:0] rs2_EX,
  input  logic              cnt_clr,
  output logic              fwd_hit_rs1,
  output logic              fwd_hit_rs2,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  logic              valid_q = 1'b0;
  logic              we_q    = 1'b0;
  logic [ADDR_W-1:0] rd_q    = '0;
  logic [SEL_W-1:0]  sel_q   = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      sel_q   <= '0;
    end else if (!bubbleW) begin
      if (flushW) begin
        valid_q <= 1'b0;
        we_q    <= 1'b0;
        rd_q    <= '0;
        sel_q   <= '0;
      end else begin
        valid_q <= bus.valid_MEM;
        // x0 writes are dropped here so the regfile never sees them
        we_q    <= bus.reg_write_en_MEM
                 & bus.valid_MEM
                 & (bus.rd_MEM != '0);
        rd_q    <= bus.rd_MEM;
        sel_q   <= bus.wb_sel_MEM;
      end
    end
  end

  assign bus.valid_WB        = valid_q;
  assign bus.reg_write_en_WB = we_q;
  assign bus.rd_WB           = rd_q;
  assign bus.wb_sel_WB       = sel_q;

  assign fwd_hit_rs1 = we_q
                     & (rd_q == rs1_EX)
                     & (rs1_EX != '0);
  assign fwd_hit_rs2 = we_q
                     & (rd_q == rs2_EX)
                     & (rs2_EX != '0);

`ifdef CTRL_WB_PERF_EN
  logic [CNT_W-1:0] ret_q = '0;
  logic [CNT_W-1:0] stl_q = '0;
  logic [CNT_W-1:0] sqh_q = '0;
  logic             ret_ev;
  logic             stl_ev;
  logic             sqh_ev;

  assign ret_ev = !bubbleW & !flushW & bus.valid_MEM;
  assign stl_ev = bubbleW & valid_q;
  assign sqh_ev = !bubbleW & flushW & bus.valid_MEM;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ret_q <= '0;
      stl_q <= '0;
      sqh_q <= '0;
    end else begin
      if (ret_ev) ret_q <= ret_q + 1'b1;
      if (stl_ev) stl_q <= stl_q + 1'b1;
      if (sqh_ev) sqh_q <= sqh_q + 1'b1;
    end
  end

  assign retire_cnt = ret_q;
  assign stall_cnt  = stl_q;
  assign squash_cnt = sqh_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign retire_cnt = '0;
  assign stall_cnt  = '0;
  assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_wb_stage.sv
// Directed bench for ctrl_wb_stage; counters expected 0 unless CTRL_WB_PERF_EN.
module tb_ctrl_wb_stage;

`ifdef CTRL_WB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       bubbleW;
  logic       flushW;
  logic [4:0] rs1_EX;
  logic [4:0] rs2_EX;
  logic       cnt_clr;
  logic       fwd_hit_rs1;
  logic       fwd_hit_rs2;
  logic [3:0] retire_cnt;
  logic [3:0] stall_cnt;
  logic [3:0] squash_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  ctrl_wb_stage_if #(.ADDR_W(5), .SEL_W(2)) bus ();

  ctrl_wb_stage #(.ADDR_W(5), .SEL_W(2), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .bubbleW     (bubbleW),
    .flushW      (flushW),
    .rs1_EX      (rs1_EX),
    .rs2_EX      (rs2_EX),
    .cnt_clr     (cnt_clr),
    .fwd_hit_rs1 (fwd_hit_rs1),
    .fwd_hit_rs2 (fwd_hit_rs2),
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt),
    .squash_cnt  (squash_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ce(input int v);
    return PERF ? 64'(v % 16) : 64'd0;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic v, input logic we,
                     input logic [4:0] rd, input logic [1:0] sel);
    bus.valid_MEM        = v;
    bus.reg_write_en_MEM = we;
    bus.rd_MEM           = rd;
    bus.wb_sel_MEM       = sel;
  endtask

  task automatic chk_wb(input string tag, input logic v,
                        input logic we, input logic [4:0] rd,
                        input logic [1:0] sel);
    chk({tag, "_valid"}, 64'(bus.valid_WB), 64'(v));
    chk({tag, "_we"}, 64'(bus.reg_write_en_WB), 64'(we));
    chk({tag, "_rd"}, 64'(bus.rd_WB), 64'(rd));
    chk({tag, "_sel"}, 64'(bus.wb_sel_WB), 64'(sel));
  endtask

  task automatic chk_cnt(input string tag, input int r,
                         input int s, input int q);
    chk({tag, "_retire"}, 64'(retire_cnt), ce(r));
    chk({tag, "_stall"}, 64'(stall_cnt), ce(s));
    chk({tag, "_squash"}, 64'(squash_cnt), ce(q));
  endtask

  initial begin
    rst = 1'b1;
    bubbleW = 1'b0;
    flushW = 1'b0;
    rs1_EX = '0;
    rs2_EX = '0;
    cnt_clr = 1'b0;
    mem(1'b0, 1'b0, 5'd0, 2'd0);
    #1;
    chk_wb("power_up", 1'b0, 1'b0, 5'd0, 2'd0);
    chk_cnt("power_up", 0, 0, 0);

    tick();
    tick();
    chk_wb("reset", 1'b0, 1'b0, 5'd0, 2'd0);
    chk_cnt("reset", 0, 0, 0);

    rst = 1'b0;
    mem(1'b1, 1'b1, 5'd5, 2'd1);
    #1;
    chk("no_comb_path_rd", 64'(bus.rd_WB), 64'd0);
    tick();
    chk_wb("load5", 1'b1, 1'b1, 5'd5, 2'd1);
    chk_cnt("load5", 1, 0, 0);

    mem(1'b1, 1'b1, 5'd0, 2'd2);
    rs1_EX = 5'd0;
    rs2_EX = 5'd0;
    tick();
    chk_wb("x0", 1'b1, 1'b0, 5'd0, 2'd2);
    chk_cnt("x0", 2, 0, 0);
    chk("x0_fwd1", 64'(fwd_hit_rs1), 64'd0);
    chk("x0_fwd2", 64'(fwd_hit_rs2), 64'd0);

    mem(1'b1, 1'b1, 5'd7, 2'd0);
    tick();
    chk_wb("load7", 1'b1, 1'b1, 5'd7, 2'd0);

    bubbleW = 1'b1;
    flushW = 1'b1;
    mem(1'b1, 1'b1, 5'd9, 2'd3);
    tick();
    tick();
    tick();
    chk_wb("bub_flush", 1'b1, 1'b1, 5'd7, 2'd0);
    chk_cnt("bub_flush", 3, 3, 0);

    bubbleW = 1'b0;
    tick();
    chk_wb("flush", 1'b0, 1'b0, 5'd0, 2'd0);
    chk_cnt("flush", 3, 3, 1);

    flushW = 1'b0;
    mem(1'b1, 1'b1, 5'd12, 2'd3);
    rs1_EX = 5'd12;
    rs2_EX = 5'd13;
    tick();
    chk_wb("load12", 1'b1, 1'b1, 5'd12, 2'd3);
    chk("fwd_rs1_hit", 64'(fwd_hit_rs1), 64'd1);
    chk("fwd_rs2_miss", 64'(fwd_hit_rs2), 64'd0);
    rs2_EX = 5'd12;
    #1;
    chk("fwd_rs2_hit", 64'(fwd_hit_rs2), 64'd1);

    flushW = 1'b1;
    mem(1'b0, 1'b1, 5'd12, 2'd3);
    tick();
    chk("flush_fwd1", 64'(fwd_hit_rs1), 64'd0);
    chk("flush_fwd2", 64'(fwd_hit_rs2), 64'd0);
    chk_cnt("flush_inv", 4, 3, 1);

    flushW = 1'b0;
    tick();
    chk_wb("inv_load", 1'b0, 1'b0, 5'd12, 2'd3);
    chk_cnt("inv_load", 4, 3, 1);

    bubbleW = 1'b1;
    tick();
    chk_cnt("stall_empty", 4, 3, 1);

    bubbleW = 1'b0;
    mem(1'b1, 1'b1, 5'd3, 2'd1);
    tick();
    chk_cnt("load3", 5, 3, 1);
    bubbleW = 1'b1;
    flushW = 1'b1;
    rst = 1'b1;
    tick();
    chk_wb("rst_mid_stall", 1'b0, 1'b0, 5'd0, 2'd0);
    chk_cnt("rst_mid_stall", 0, 0, 0);

    rst = 1'b0;
    bubbleW = 1'b0;
    flushW = 1'b0;
    mem(1'b1, 1'b1, 5'd1, 2'd0);
    for (int i = 0; i < 15; i++) tick();
    chk_wb("wrap_stage", 1'b1, 1'b1, 5'd1, 2'd0);
    chk_cnt("retire15", 15, 0, 0);
    tick();
    chk_cnt("retire_wrap", 0, 0, 0);
    tick();
    tick();
    chk_cnt("retire2", 2, 0, 0);

    bubbleW = 1'b1;
    tick();
    tick();
    chk_cnt("stall2", 2, 2, 0);

    bubbleW = 1'b0;
    cnt_clr = 1'b1;
    tick();
    chk_cnt("clr_with_retire", 0, 0, 0);
    chk_wb("clr_stage", 1'b1, 1'b1, 5'd1, 2'd0);

    cnt_clr = 1'b0;
    tick();
    chk_cnt("after_clr", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
